i2c_reg_ctrl: RTL and testbench

- Register-bank controller placed behind the I2C slave byte engine (same clk/reset domain).
- Sequences the byte stream: first byte after START is the register pointer, later written bytes go to the bank, read bytes are sourced from the bank. The pointer auto-increments after every byte.
- Shares the bank between the I2C side and a local host write port, with fixed priority.

---
 rtl/i2c_reg_ctrl.sv | 132 +++++++++++++
 tb/tb_i2c_reg_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_ctrl.sv
// Register-bank controller behind an I2C slave byte engine.
// The first byte after START loads the register pointer. Later received bytes are
// written to the bank, and transmitted bytes are read from it. The pointer
// auto-increments after each data byte. A local host port shares the bank, and
// I2C writes take priority over host writes.
module i2c_reg_ctrl #(
    parameter int unsigned             ADDR_W  = 4,
    parameter logic [2**ADDR_W-1:0]    RO_MASK = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i2c_start,
    input  logic              i2c_stop,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic [7:0]        host_rdata,
    output logic              host_collision,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] ptr,
    output logic              busy
);

    localparam int unsigned        Depth  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0]  PtrOne = ADDR_W'(1);

    typedef enum logic [1:0] {StIdle, StGetPtr, StWrite, StRead} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [7:0]        bank_q [Depth];
    logic              rx_last_q, tx_last_q;
    logic [7:0]        tx_data_q, host_rdata_q;
    logic              wr_strobe_q, coll_q;
    logic [ADDR_W-1:0] wr_addr_q;

    logic rx_ev, tx_ev, byte_ok, i2c_acc, host_hit, host_acc;

    // Byte events are one-shot rising edges of the slave status levels. They are
    // dropped when a START or STOP arrives in the same cycle.
    always_comb begin
        rx_ev    = rx_ready & ~rx_last_q;
        tx_ev    = tx_ready & ~tx_last_q;
        byte_ok  = ~i2c_stop & ~i2c_start;
        i2c_acc  = (state_q == StWrite) & rx_ev & byte_ok & ~RO_MASK[ptr_q];
        host_hit = host_we & i2c_acc & (host_addr == ptr_q);
        host_acc = host_we & ~host_hit;
    end

    // Transaction sequencer: pointer load, write or read phases, and pointer increment.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
        end else if (i2c_stop) begin
            state_q <= StIdle;
        end else if (i2c_start) begin
            state_q <= StGetPtr;
        end else begin
            unique case (state_q)
                StIdle: ;
                StGetPtr: begin
                    if (rx_ev) begin
                        ptr_q   <= rx_data[ADDR_W-1:0];
                        state_q <= StWrite;
                    end else if (tx_ev) begin
                        ptr_q   <= ptr_q + PtrOne;
                        state_q <= StRead;
                    end
                end
                StWrite: begin
                    // The pointer advances even when the target is read-only.
                    if (rx_ev) begin
                        ptr_q <= ptr_q + PtrOne;
                    end else if (tx_ev) begin
                        ptr_q   <= ptr_q + PtrOne;
                        state_q <= StRead;
                    end
                end
                StRead: begin
                    if (tx_ev) ptr_q <= ptr_q + PtrOne;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Bank storage. On a same-address clash the I2C write wins over the host write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < Depth; i++) bank_q[i] <= 8'h00;
        end else begin
            if (i2c_acc)  bank_q[ptr_q]     <= rx_data;
            if (host_acc) bank_q[host_addr] <= host_wdata;
        end
    end

    // Registered outputs, edge-detect history and status pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_last_q    <= 1'b0;
            tx_last_q    <= 1'b0;
            tx_data_q    <= 8'h00;
            host_rdata_q <= 8'h00;
            wr_strobe_q  <= 1'b0;
            wr_addr_q    <= '0;
            coll_q       <= 1'b0;
        end else begin
            rx_last_q    <= rx_ready;
            tx_last_q    <= tx_ready;
            tx_data_q    <= bank_q[ptr_q];
            host_rdata_q <= bank_q[host_addr];
            wr_strobe_q  <= i2c_acc;
            coll_q       <= host_hit;
            if (i2c_acc) wr_addr_q <= ptr_q;
        end
    end

    assign tx_data        = tx_data_q;
    assign host_rdata     = host_rdata_q;
    assign host_collision = coll_q;
    assign wr_strobe      = wr_strobe_q;
    assign wr_addr        = wr_addr_q;
    assign ptr            = ptr_q;
    assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Self-checking bench for i2c_reg_ctrl (ADDR_W=4, register 0 read-only from I2C).
module tb_i2c_reg_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       i2c_start = 1'b0, i2c_stop = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready = 1'b0, tx_ready = 1'b0;
    logic [7:0] tx_data;
    logic       host_we = 1'b0;
    logic [3:0] host_addr = 4'h0;
    logic [7:0] host_wdata = 8'h00;
    logic [7:0] host_rdata;
    logic       host_collision, wr_strobe, busy;
    logic [3:0] wr_addr, ptr;

    i2c_reg_ctrl #(.ADDR_W(4), .RO_MASK(16'h0001)) dut (
        .clk(clk), .reset(reset), .i2c_start(i2c_start), .i2c_stop(i2c_stop),
        .rx_data(rx_data), .rx_ready(rx_ready), .tx_ready(tx_ready), .tx_data(tx_data),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_collision(host_collision), .wr_strobe(wr_strobe),
        .wr_addr(wr_addr), .ptr(ptr), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int coll_cnt = 0;
    logic [3:0] wr_q [$];     // expected wr_addr of each I2C write, in order
    logic [7:0] rd_q [$];     // expected host_rdata for table vectors

    typedef struct {
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;  // bank[addr] before this vector's write
    } hvec_t;
    hvec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        i2c_start = 1'b1; tick(); i2c_start = 1'b0; tick();
    endtask

    task automatic pulse_stop();
        i2c_stop = 1'b1; tick(); i2c_stop = 1'b0; tick();
    endtask

    task automatic rx_byte(input logic [7:0] b, input int hold);
        rx_data = b; rx_ready = 1'b1;
        repeat (hold) tick();
        rx_ready = 1'b0;
        tick(); tick();
    endtask

    task automatic tx_byte();
        tx_ready = 1'b1; tick(); tick(); tx_ready = 1'b0; tick();
    endtask

    task automatic check_reg(input string name, input logic [3:0] a, input logic [7:0] exp);
        host_addr = a;
        tick();
        check(name, host_rdata, exp);
    endtask

    // Scoreboard: every wr_strobe pulse consumes one expected write address.
    always @(negedge clk) begin
        logic [3:0] e;
        if (reset && wr_strobe) begin
            if (wr_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL wr_strobe: unexpected pulse wr_addr=0x%0h, expected none", wr_addr);
            end else begin
                e = wr_q.pop_front();
                check("wr_addr", wr_addr, e);
            end
        end
        if (reset && host_collision) coll_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] e;
        tbl[0]  = '{1'b1, 4'd5, 8'h11, 8'h00};
        tbl[1]  = '{1'b1, 4'd6, 8'h22, 8'h00};
        tbl[2]  = '{1'b1, 4'd7, 8'h33, 8'h00};
        tbl[3]  = '{1'b0, 4'd5, 8'hFF, 8'h11};
        tbl[4]  = '{1'b0, 4'd6, 8'hFF, 8'h22};
        tbl[5]  = '{1'b0, 4'd7, 8'hFF, 8'h33};
        tbl[6]  = '{1'b1, 4'd0, 8'hA5, 8'h00};
        tbl[7]  = '{1'b0, 4'd0, 8'h00, 8'hA5};
        tbl[8]  = '{1'b1, 4'd0, 8'h00, 8'hA5};
        tbl[9]  = '{1'b0, 4'd0, 8'h00, 8'h00};
        tbl[10] = '{1'b1, 4'd9, 8'h5A, 8'h00};
        tbl[11] = '{1'b0, 4'd9, 8'h00, 8'h5A};

        // Reset state
        tick(); tick();
        check("rst_ptr", ptr, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_host_rdata", host_rdata, 0);
        check("rst_wr_strobe", wr_strobe, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_collision", host_collision, 0);
        reset = 1'b1;
        tick();

        // Host port table
        for (int i = 0; i < 12; i++) begin
            host_we = tbl[i].we; host_addr = tbl[i].addr; host_wdata = tbl[i].wdata;
            rd_q.push_back(tbl[i].exp_rdata);
            tick();
            host_we = 1'b0;
            e = rd_q.pop_front();
            check($sformatf("host_vec%0d", i), host_rdata, e);
        end

        // Write burst
        pulse_start();
        check("burst_busy", busy, 1);
        rx_byte(8'h02, 3);
        wr_q.push_back(4'd2); rx_byte(8'hAA, 3);
        wr_q.push_back(4'd3); rx_byte(8'hBB, 3);
        pulse_stop();
        check("burst_busy_after_stop", busy, 0);
        check("burst_ptr", ptr, 4);
        check_reg("burst_reg2", 4'd2, 8'hAA);
        check_reg("burst_reg3", 4'd3, 8'hBB);

        // Random read through repeated START
        pulse_start();
        rx_byte(8'h05, 2);
        pulse_start();
        check("read_tx0", tx_data, 8'h11);
        tx_byte();
        check("read_tx1", tx_data, 8'h22);
        tx_byte();
        check("read_tx2", tx_data, 8'h33);
        tx_byte();
        check("read_ptr", ptr, 8);
        pulse_stop();

        // Pointer wrap and read-only register 0
        pulse_start();
        rx_byte(8'h0F, 2);
        wr_q.push_back(4'd15); rx_byte(8'h55, 2);
        rx_byte(8'h66, 2);
        pulse_stop();
        check("wrap_ptr", ptr, 1);
        check_reg("wrap_reg15", 4'd15, 8'h55);
        check_reg("ro_reg0", 4'd0, 8'h00);

        // Collision: same address
        pulse_start();
        rx_byte(8'h03, 2);
        rx_data = 8'h9C; rx_ready = 1'b1;
        host_we = 1'b1; host_addr = 4'd3; host_wdata = 8'h01;
        wr_q.push_back(4'd3);
        tick();
        host_we = 1'b0;
        check("coll_pulse", host_collision, 1);
        tick();
        check("coll_pulse_end", host_collision, 0);
        rx_ready = 1'b0; tick();
        check_reg("coll_reg3", 4'd3, 8'h9C);
        // Different addresses: both writes land
        pulse_start();
        rx_byte(8'h03, 2);
        rx_data = 8'h9D; rx_ready = 1'b1;
        host_we = 1'b1; host_addr = 4'd4; host_wdata = 8'h01;
        wr_q.push_back(4'd3);
        tick();
        host_we = 1'b0;
        check("nocoll_pulse", host_collision, 0);
        rx_ready = 1'b0; tick();
        pulse_stop();
        check_reg("nocoll_reg3", 4'd3, 8'h9D);
        check_reg("nocoll_reg4", 4'd4, 8'h01);

        // Long rx_ready level, then rx event coincident with STOP
        pulse_start();
        rx_byte(8'h08, 2);
        wr_q.push_back(4'd8); rx_byte(8'h42, 50);
        check("long_ptr", ptr, 9);
        check_reg("long_reg8", 4'd8, 8'h42);
        rx_data = 8'h99; rx_ready = 1'b1; i2c_stop = 1'b1;
        tick();
        i2c_stop = 1'b0;
        check("stop_rx_ptr", ptr, 9);
        check("stop_rx_busy", busy, 0);
        tick(); rx_ready = 1'b0; tick();
        check_reg("stop_rx_reg9", 4'd9, 8'h5A);

        // Reset in the middle of a write transaction
        pulse_start();
        rx_byte(8'h0A, 2);
        reset = 1'b0; tick(); reset = 1'b1;
        check("midrst_ptr", ptr, 0);
        check("midrst_busy", busy, 0);
        rx_byte(8'h77, 2);
        check("midrst_ptr_after_rx", ptr, 0);
        check("midrst_busy_after_rx", busy, 0);
        for (int i = 0; i < 16; i++) check_reg($sformatf("midrst_reg%0d", i), 4'(i), 8'h00);
        check("midrst_tx_data", tx_data, 8'h00);

        tick();
        check("wr_queue_drained", wr_q.size(), 0);
        check("collision_count", coll_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
